// File: rtl/rv_scb_pkg.sv
// Shared definitions for the destination-register scoreboard: register index width,
// RV32 major opcodes and the operand-usage decode shared with the forwarding unit.
package rv_scb_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // Only opcode bits [6:2] distinguish the formats; [1:0] are always 2'b11.
    function automatic logic uses_rs1(input logic [6:2] op);
        return (op[6] & ~op[3]) | ~op[2];
    endfunction

    function automatic logic uses_rs2(input logic [6:2] op);
        return op[5] & ~op[2] & ~(op[6] & op[4]);
    endfunction

    function automatic logic writes_rd(input logic [6:2] op);
        return ~(op[5] & ~op[4] & ~op[2]);
    endfunction

endpackage

// File: rtl/scb_decode.sv
// Combinational opcode decode: which register fields an instruction actually uses.
module scb_decode (
    input  logic [6:0] op,
    output logic       rs1_used,
    output logic       rs2_used,
    output logic       rd_written
);

    logic unused_op_lsb;

    assign rs1_used      = rv_scb_pkg::uses_rs1(op[6:2]);
    assign rs2_used      = rv_scb_pkg::uses_rs2(op[6:2]);
    assign rd_written    = rv_scb_pkg::writes_rd(op[6:2]);
    assign unused_op_lsb = ^op[1:0];

endmodule

// File: rtl/rd_scoreboard.sv
// Destination-register scoreboard: per-register pending-write counters, RAW/overflow issue
// hazard and sticky underflow flag. Optional macro SCB_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module rd_scoreboard
    import rv_scb_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [6:0]       iss_op,
    input  logic [REG_W-1:0] iss_rs1,
    input  logic [REG_W-1:0] iss_rs2,
    input  logic [REG_W-1:0] iss_rd,
    output logic             iss_ready,
    output logic             stall,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             flush,
    output logic [NREG-1:0]  busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREG];
    logic             rs1_used, rs2_used, rd_written;
    logic             src1_hz, src2_hz, dst_hz, accept, underflow;
    logic [NREG-1:0]  inc, dec;

    scb_decode u_decode (
        .op         (iss_op),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used),
        .rd_written (rd_written)
    );

    always_comb begin
        src1_hz = rs1_used && iss_rs1 != '0 && cnt[iss_rs1] != '0;
        src2_hz = rs2_used && iss_rs2 != '0 && cnt[iss_rs2] != '0;
        dst_hz  = rd_written && iss_rd != '0 && cnt[iss_rd] == CNT_MAX;
`ifdef SCB_WB_BYPASS_EN
        // A retiring write frees its slot in the same cycle the dependent instruction looks.
        if (wb_valid && wb_rd == iss_rs1 && cnt[iss_rs1] == CNT_ONE) src1_hz = 1'b0;
        if (wb_valid && wb_rd == iss_rs2 && cnt[iss_rs2] == CNT_ONE) src2_hz = 1'b0;
        if (wb_valid && wb_rd == iss_rd) dst_hz = 1'b0;
`endif
    end

    assign iss_ready = ~(src1_hz | src2_hz | dst_hz);
    assign stall     = iss_valid & ~iss_ready;
    assign accept    = iss_valid & iss_ready;

    always_comb begin
        inc = '0;
        dec = '0;
        if (accept && rd_written && iss_rd != '0) inc[iss_rd] = 1'b1;
        if (wb_valid && wb_rd != '0) dec[wb_rd] = 1'b1;
        underflow = wb_valid && wb_rd != '0 && cnt[wb_rd] == '0 && !inc[wb_rd] && !flush;
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) busy[i] = cnt[i] != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else begin
                    // Issue and retire on the same register cancel out; x0 never sees inc/dec.
                    case ({inc[i], dec[i]})
                        2'b10:   if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
                        2'b01:   if (cnt[i] != '0)      cnt[i] <= cnt[i] - CNT_ONE;
                        default: cnt[i] <= cnt[i];
                    endcase
                end
            end
            err <= err | underflow;
        end
    end

endmodule
